// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared UART definitions: arbiter states and defaults
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int UART_NUM_REQ      = 4;
    localparam int UART_BUSY_TIMEOUT = 3;

    // Width of a counter that must hold values 0..max_val
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - round-robin winner selection with lock filtering
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               lock_held,
    input  logic [IDX_W-1:0]   grant_idx,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   cand;

    // Under a lock only the current owner may compete
    always_comb begin
        eligible = valid;
        if (lock_held) begin
            eligible = valid & (NUM_REQ'(1) << grant_idx);
        end
    end

    // Scan rr_ptr+NUM_REQ down to rr_ptr+1 so the nearest eligible index is written last
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (eligible[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - arbitrates byte requesters onto a single UART transmitter
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = UART_NUM_REQ,
    parameter int BUSY_TIMEOUT = UART_BUSY_TIMEOUT
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_en,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_active,
    output logic                       frame_done,
    output logic                       err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic             lock_held;
    logic [CNT_W-1:0] busy_cnt;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             accept;
    logic             timeout_hit;
    logic             done_hit;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .lock_held (lock_held),
        .grant_idx (grant_idx),
        .winner    (winner),
        .found     (found)
    );

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus decoded strobes; accepts are blocked while the transmitter
    // is busy and during the frame_done cycle so a new frame never overlaps the old one
    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        accept       = 1'b0;
        timeout_hit  = 1'b0;
        done_hit     = 1'b0;
        tx_en        = 1'b0;
        grant_active = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!tx_busy && !frame_done && found) begin
                    req_ready = NUM_REQ'(1) << winner;
                    accept    = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tx_en        = 1'b1;
                grant_active = 1'b1;
                state_nxt    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                grant_active = 1'b1;
                if (tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (busy_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                grant_active = 1'b1;
                if (!tx_busy) begin
                    done_hit  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winner's byte, ownership and lock on accept; a timeout drops the lock
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_data   <= 8'h00;
            grant_idx <= '0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            lock_held <= 1'b0;
        end else if (accept) begin
            tx_data   <= req_data[{winner, 3'b000} +: 8];
            grant_idx <= winner;
            rr_ptr    <= winner;
            lock_held <= req_lock[winner];
        end else if (timeout_hit) begin
            lock_held <= 1'b0;
        end
    end

    // Count WAIT_BUSY cycles spent without tx_busy
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_cnt <= '0;
        end else if (state == ST_WAIT_BUSY && !tx_busy && !timeout_hit) begin
            busy_cnt <= busy_cnt + 1'b1;
        end else begin
            busy_cnt <= '0;
        end
    end

    // Registered one-cycle completion and error pulses
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            frame_done  <= done_hit;
            err_timeout <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int BT   = 3;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_lock;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [1:0]        grant_idx;
    logic              grant_active;
    logic              frame_done;
    logic              err_timeout;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req_valid    (req_valid),
        .req_lock     (req_lock),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant_idx    (grant_idx),
        .grant_active (grant_active),
        .frame_done   (frame_done),
        .err_timeout  (err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] lock;
        logic       busy;
        logic [3:0] exp_ready;
    } vec_t;

    vec_t tv[12];

    // Per-requester byte queues and the transaction-level reference model
    logic [7:0] qd[NREQ][$];
    logic       ql[NREQ][$];
    int         order_q[$];
    logic [7:0] data_q[$];
    int         m_ptr;
    int         m_owner;
    bit         m_lock;

    function automatic int model_pick();
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (qd[i].size() != 0 && (!m_lock || i == m_owner)) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // Drive a frame that has just been accepted through to frame_done
    task automatic run_frame(input int exp_idx, input logic [7:0] exp_data);
        @(negedge sys_clk);
        req_valid = '0;
        req_lock  = '0;
        tx_busy   = 1'b0;
        #1;
        check("frame_tx_en", tx_en, 1);
        check("frame_grant_idx", grant_idx, exp_idx);
        check("frame_tx_data", tx_data, exp_data);
        @(negedge sys_clk);
        tx_busy = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        tx_busy = 1'b0;
        @(negedge sys_clk);
        #1;
        check("frame_done_pulse", frame_done, 1);
    endtask

    // Queue-driven requesters plus a transmitter that answers resp_pct% of frames
    task automatic run_engine(input int resp_pct, input int budget);
        int cyc = 0;
        int busy_on = -1;
        int busy_off = -1;
        int exp_w;
        int fd_exp = 0;
        int to_exp = 0;
        int fd_seen = 0;
        int to_seen = 0;
        logic [7:0] cur_data = 8'h00;
        m_ptr = NREQ - 1;
        m_lock = 1'b0;
        m_owner = 0;
        order_q.delete();
        data_q.delete();
        while (cyc < budget) begin
            @(negedge sys_clk);
            tx_busy = (cyc >= busy_on) && (cyc < busy_off);
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = (qd[i].size() != 0);
                req_data[8*i +: 8] = req_valid[i] ? qd[i][0] : 8'h00;
                req_lock[i] = req_valid[i] ? ql[i][0] : 1'b0;
            end
            #1;
            if (frame_done) fd_seen++;
            if (err_timeout) to_seen++;
            if (grant_active) check("rand_tx_data_hold", tx_data, cur_data);
            if (tx_en) begin
                check("rand_grant_idx", grant_idx, m_owner);
                if ($urandom_range(0, 99) < resp_pct) begin
                    busy_on  = cyc + 1 + $urandom_range(0, BT - 1);
                    busy_off = busy_on + $urandom_range(1, 4);
                    fd_exp++;
                end else begin
                    busy_on  = -1;
                    busy_off = -1;
                    to_exp++;
                    m_lock = 1'b0;
                end
            end
            if (req_ready != '0) begin
                exp_w = model_pick();
                if (exp_w < 0) begin
                    check("rand_unexpected_accept", req_ready, 0);
                end else begin
                    check("rand_ready", req_ready, 32'(1) << exp_w);
                    cur_data = qd[exp_w].pop_front();
                    m_lock   = ql[exp_w].pop_front();
                    m_owner  = exp_w;
                    m_ptr    = exp_w;
                    order_q.push_back(exp_w);
                    data_q.push_back(cur_data);
                end
            end else begin
                exp_w = 0;
                for (int i = 0; i < NREQ; i++) exp_w += qd[i].size();
                if (exp_w == 0 && !grant_active) break;
            end
            cyc++;
        end
        if (cyc >= budget) check("rand_budget_expired", cyc, 0);
        check("rand_frame_done_count", fd_seen, fd_exp);
        check("rand_timeout_count", to_seen, to_exp);
        req_valid = '0;
        req_lock  = '0;
        tx_busy   = 1'b0;
    endtask

    initial begin
        int exp_i;
        int exp_order[8];
        logic [7:0] exp_bytes[4];

        // Reset state
        do_reset();
        sys_rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_grant_active", grant_active, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_timeout", err_timeout, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Single byte from requester 2, then frame_done blocks the next accept for one cycle
        @(negedge sys_clk);
        req_valid = 4'b0100;
        req_data[23:16] = 8'h5A;
        #1;
        check("single_ready", req_ready, 4'b0100);
        check("single_no_tx_en_yet", tx_en, 0);
        @(negedge sys_clk);
        req_valid = '0;
        #1;
        check("single_tx_en", tx_en, 1);
        check("single_grant_idx", grant_idx, 2);
        check("single_tx_data", tx_data, 8'h5A);
        check("single_grant_active", grant_active, 1);
        @(negedge sys_clk);
        tx_busy = 1'b1;
        #1;
        check("single_tx_en_one_cycle", tx_en, 0);
        @(negedge sys_clk);
        #1;
        check("single_tx_data_hold", tx_data, 8'h5A);
        @(negedge sys_clk);
        tx_busy = 1'b0;
        req_valid = 4'b0100;
        req_data[23:16] = 8'h5B;
        #1;
        check("single_no_ready_wait_done", req_ready, 0);
        check("single_tx_data_hold2", tx_data, 8'h5A);
        @(negedge sys_clk);
        #1;
        check("single_frame_done", frame_done, 1);
        check("single_no_accept_on_done", req_ready, 0);
        @(negedge sys_clk);
        #1;
        check("single_done_one_cycle", frame_done, 0);
        check("single_accept_after_done", req_ready, 4'b0100);

        // Table-driven arbitration vectors, state carried from one row to the next
        tv[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
        tv[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000};
        tv[2]  = '{4'b1010, 4'b0000, 1'b0, 4'b0010};
        tv[3]  = '{4'b1011, 4'b0000, 1'b0, 4'b1000};
        tv[4]  = '{4'b0110, 4'b0010, 1'b0, 4'b0010};
        tv[5]  = '{4'b1101, 4'b0000, 1'b0, 4'b0000};
        tv[6]  = '{4'b1111, 4'b0000, 1'b0, 4'b0010};
        tv[7]  = '{4'b1111, 4'b0000, 1'b0, 4'b0100};
        tv[8]  = '{4'b0011, 4'b0000, 1'b0, 4'b0001};
        tv[9]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001};
        tv[10] = '{4'b1000, 4'b0000, 1'b1, 4'b0000};
        tv[11] = '{4'b1000, 4'b0000, 1'b0, 4'b1000};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
            req_valid = tv[i].valid;
            req_lock  = tv[i].lock;
            tx_busy   = tv[i].busy;
            #1;
            check($sformatf("vec%0d_ready", i), req_ready, tv[i].exp_ready);
            if (tv[i].exp_ready != 4'b0000) begin
                exp_i = 0;
                for (int b = 0; b < NREQ; b++) if (tv[i].exp_ready[b]) exp_i = b;
                run_frame(exp_i, 8'hA0 + 8'(exp_i));
            end
        end

        // Fairness: every requester has two bytes, no locks
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            qd[i].delete();
            ql[i].delete();
            repeat (2) begin
                qd[i].push_back(8'(8'h40 + i));
                ql[i].push_back(1'b0);
            end
        end
        run_engine(100, 2000);
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        check("fair_count", order_q.size(), 8);
        for (int i = 0; i < 8 && i < order_q.size(); i++)
            check($sformatf("fair_order%0d", i), order_q[i], exp_order[i]);

        // Lock: requester 1 holds the grant for three bytes while requester 3 waits
        do_reset();
        qd[1] = '{8'h10, 8'h11, 8'h12};
        ql[1] = '{1'b1, 1'b1, 1'b0};
        qd[3] = '{8'h33};
        ql[3] = '{1'b0};
        run_engine(100, 2000);
        exp_bytes = '{8'h10, 8'h11, 8'h12, 8'h33};
        check("lock_count", order_q.size(), 4);
        for (int i = 0; i < 4 && i < order_q.size(); i++) begin
            check($sformatf("lock_idx%0d", i), order_q[i], (i < 3) ? 1 : 3);
            check($sformatf("lock_byte%0d", i), data_q[i], exp_bytes[i]);
        end

        // Timeout with a locked byte: pulse 3 cycles after WAIT_BUSY entry, lock released
        do_reset();
        @(negedge sys_clk);
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'b0001;
        req_lock  = 4'b0001;
        #1;
        check("to_ready", req_ready, 4'b0001);
        @(negedge sys_clk);
        req_valid = '0;
        req_lock  = '0;
        #1;
        check("to_tx_en", tx_en, 1);
        for (int c = 0; c < BT; c++) begin
            @(negedge sys_clk);
            #1;
            check($sformatf("to_wait%0d_err", c), err_timeout, 0);
            check($sformatf("to_wait%0d_active", c), grant_active, 1);
        end
        @(negedge sys_clk);
        #1;
        check("to_err_pulse", err_timeout, 1);
        check("to_no_frame_done", frame_done, 0);
        check("to_back_idle", grant_active, 0);
        @(negedge sys_clk);
        req_valid = 4'b0100;
        #1;
        check("to_err_one_cycle", err_timeout, 0);
        check("to_lock_released", req_ready, 4'b0100);

        // Mid-frame reset while the transmitter stays busy
        do_reset();
        @(negedge sys_clk);
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'b0100;
        @(negedge sys_clk);
        req_valid = '0;
        @(negedge sys_clk);
        tx_busy = 1'b1;
        @(negedge sys_clk);
        #1;
        check("mr_in_frame", grant_active, 1);
        #2;
        sys_rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("mr_async_active", grant_active, 0);
        check("mr_async_tx_data", tx_data, 0);
        check("mr_async_grant_idx", grant_idx, 0);
        check("mr_async_ready", req_ready, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge sys_clk);
            #1;
            check($sformatf("mr_busy_block%0d", c), req_ready, 0);
        end
        @(negedge sys_clk);
        tx_busy = 1'b0;
        #1;
        check("mr_first_priority", req_ready, 4'b0001);

        // Randomized traffic against the reference model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < NREQ; i++) begin
                int n;
                qd[i].delete();
                ql[i].delete();
                n = $urandom_range(0, 5);
                for (int j = 0; j < n; j++) begin
                    qd[i].push_back(8'($urandom));
                    ql[i].push_back((j == n - 1) ? 1'b0 : 1'($urandom_range(0, 1)));
                end
            end
            run_engine(80, 3000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, sets the number of requesters (2..8).
REQ-002 Parameter BUSY_TIMEOUT, default 3, is the cycles allowed between tx_en and tx_busy rising.
REQ-003 Port sys_clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port sys_rst_n  input  1  is an asynchronous, active-low reset.
REQ-005 Port req_valid  input  NUM_REQ  is a per-requester byte-available flag, held until accepted.
REQ-006 Port req_lock  input  NUM_REQ  is a per-requester request to keep the grant for its next byte.
REQ-007 Port req_data  input  8*NUM_REQ  is the byte for requester i on bits [8i+7:8i].
REQ-008 Port req_ready  output  NUM_REQ  is a one-hot accept strobe; a byte transfers when valid and ready are both high.
REQ-009 Port tx_en  output  1  is the one-cycle start pulse to the UART transmitter.
REQ-010 Port tx_data  output  8  is the byte to the transmitter, stable for the whole frame.
REQ-011 Port tx_busy  input  1  is the transmitter busy flag.
REQ-012 Port grant_idx  output  clog2(NUM_REQ)  is the index of the requester owning the current frame.
REQ-013 Port grant_active  output  1  is high from LAUNCH through the end of WAIT_DONE.
REQ-014 Port frame_done  output  1  is a one-cycle pulse on frame completion.
REQ-015 Port err_timeout  output  1  is a one-cycle pulse when tx_busy fails to rise.

Function
REQ-016 The FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-017 In IDLE with tx_busy=0 and any eligible req_valid, the arbiter SHALL assert req_ready for exactly one winner, combinationally, in the same cycle.
REQ-018 Winner selection SHALL be round-robin, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ, where rr_ptr is the last accepted index.
REQ-019 While lock_held=1, only requester grant_idx SHALL be eligible; other requesters wait regardless of their valid.
REQ-020 On accept, the arbiter SHALL register:
  - data into tx_data;
  - winner into grant_idx and rr_ptr;
  - req_lock[winner] into lock_held;
  then move to LAUNCH.
REQ-021 LAUNCH SHALL last one cycle with tx_en=1 (decoded from state), then move to WAIT_BUSY.
REQ-022 WAIT_BUSY behaviour:
  - tx_busy=1 moves to WAIT_DONE;
  - otherwise the counter increments;
  - at BUSY_TIMEOUT cycles, pulse err_timeout, clear lock_held and return to IDLE without frame_done.
REQ-023 WAIT_DONE SHALL hold until tx_busy=0, then pulse frame_done for one cycle and return to IDLE.
REQ-024 A new byte SHALL NOT be accepted in the same cycle frame_done is high; earliest accept is the following cycle.
REQ-025 tx_data SHALL NOT change between accept and the return to IDLE.
REQ-026 If tx_busy=1 while in IDLE (e.g. after a reset mid-frame), all req_ready SHALL stay low until tx_busy=0.
REQ-027 If the locked requester drops valid, the arbiter SHALL wait in IDLE with lock_held=1; the lock releases only on an accepted byte with req_lock=0, or on timeout.
REQ-028 req_valid deasserted in the cycle a request would win SHALL produce no accept and no state change.

Reset
REQ-029 While sys_rst_n=0, the arbiter SHALL immediately (asynchronously) drive:
  - state=IDLE, req_ready=0, tx_en=0, tx_data=0;
  - grant_idx=0, grant_active=0, frame_done=0, err_timeout=0;
  - rr_ptr=NUM_REQ-1, lock_held=0, timeout counter=0.
REQ-030 After reset release, requester 0 SHALL have first priority.

Structure
REQ-031 State encodings and the default BUSY_TIMEOUT SHALL live in the shared UART definitions package used by the UART blocks.
REQ-032 Winner selection SHALL be one combinational sub-module, uart_rr_pick, with inputs valid, rr_ptr, lock_held and grant_idx, and outputs winner index and found.

Verification
REQ-033 Single byte: after reset, req_valid[2]=1 with data 0x5A. Required: req_ready[2] pulses, tx_en pulses one cycle later, tx_data=0x5A until frame_done, grant_idx=2.
REQ-034 Fairness: all four valid continuously, lock=0. Required: grant order 0,1,2,3,0; exactly one frame_done per byte.
REQ-035 Lock: requester 1 sends 0x10 (lock=1), 0x11 (lock=1), 0x12 (lock=0) while requester 3 is valid throughout. Required: bytes 0x10, 0x11, 0x12 are transmitted back to back, then requester 3 is granted.
REQ-036 Timeout: tx_busy tied low with BUSY_TIMEOUT=3. Required: err_timeout pulses 3 cycles after WAIT_BUSY entry, no frame_done, lock_held=0, back to IDLE.
REQ-037 Mid-frame reset: assert sys_rst_n=0 during WAIT_DONE while the transmitter stays busy. Required: outputs reset immediately, and no req_ready until tx_busy falls.
